// File: rtl/param_serial_alu_if.sv
// Serial-opcode ALU bus: request/operand signals from the driver,
// busy/done/result back from the ALU.
interface param_serial_alu_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  opcode_valid;
    logic                  opcode;
    logic [DATA_WIDTH-1:0] data;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic [DATA_WIDTH-1:0] result;

    modport master (
        output opcode_valid, opcode, data,
        input  busy, done, overflow, result
    );

    modport slave (
        input  opcode_valid, opcode, data,
        output busy, done, overflow, result
    );
endinterface

// File: rtl/param_serial_alu.sv
// Serial-opcode ALU: LSB-first opcode, two operands, level done.
// Define PSALU_SAT_EN for saturating ADD/SUB/MUL results.
module param_serial_alu #(
    parameter int DATA_WIDTH = 8,
    parameter int OP_BITS    = 3
) (
    input logic              clk,
    input logic              reset_n,
    param_serial_alu_if.slave bus
);
    localparam int N = DATA_WIDTH;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] EXEC    = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_PAR  = 3'd2;
    localparam logic [2:0] OP_COMP = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [2:0] OP_MUL  = 3'd7;

    localparam logic [1:0] LAST = 2'(OP_BITS - 1);

    logic [1:0]     state;
    logic [1:0]     cnt;
    logic [2:0]     op_r;
    logic [N-1:0]   a_r;
    logic [N-1:0]   b_r;
    logic [N-1:0]   res_q;
    logic           ovf_q;
    logic           done_q;

    logic [N:0]     sum;
    logic [N:0]     diff;
    logic [2*N-1:0] prod;
    logic [N-1:0]   alu_res;
    logic           alu_ovf;

    assign sum  = {1'b0, a_r} + {1'b0, b_r};
    assign diff = {1'b0, a_r} - {1'b0, b_r};
    assign prod = {{N{1'b0}}, a_r} * {{N{1'b0}}, b_r};

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        unique case (op_r)
            OP_ADD: begin
                alu_res = sum[N-1:0];
                alu_ovf = sum[N];
            end
            OP_SUB: begin
                alu_res = diff[N-1:0];
                alu_ovf = diff[N];
            end
            OP_PAR:  alu_res = {{(N-1){1'b0}}, ^{a_r, b_r}};
            OP_COMP: alu_res = {{(N-3){1'b0}},
                                a_r < b_r,
                                a_r > b_r,
                                a_r == b_r};
            OP_AND:  alu_res = a_r & b_r;
            OP_OR:   alu_res = a_r | b_r;
            OP_XOR:  alu_res = a_r ^ b_r;
            OP_MUL: begin
                alu_res = prod[N-1:0];
                alu_ovf = |prod[2*N-1:N];
            end
            default: alu_res = '0;
        endcase
`ifdef PSALU_SAT_EN
        if (alu_ovf) begin
            case (op_r)
                OP_ADD:  alu_res = '1;
                OP_MUL:  alu_res = '1;
                OP_SUB:  alu_res = '0;
                default: ;
            endcase
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            res_q  <= '0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.opcode_valid) begin
                        op_r  <= {2'b00, bus.opcode};
                        a_r   <= bus.data;
                        cnt   <= 2'd1;
                        state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (!bus.opcode_valid) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        op_r[cnt] <= bus.opcode;
                        if (cnt == 2'd1)
                            b_r <= bus.data;
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= EXEC;
                        end else begin
                            cnt <= cnt + 2'd1;
                        end
                    end
                end
                EXEC: begin
                    res_q  <= alu_res;
                    ovf_q  <= alu_ovf;
                    done_q <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    if (!bus.opcode_valid) begin
                        done_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_q;
    assign bus.overflow = ovf_q;
    assign bus.result   = res_q;
endmodule

// File: tb/tb_param_serial_alu.sv
// Directed bench for param_serial_alu (DATA_WIDTH=8, OP_BITS=3).
// Inputs change and outputs are sampled on the falling edge.
module tb_param_serial_alu;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    param_serial_alu_if #(.DATA_WIDTH(8)) bus ();

    param_serial_alu #(
        .DATA_WIDTH(8),
        .OP_BITS   (3)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

`ifdef PSALU_SAT_EN
    localparam logic [7:0] ADD_EXP = 8'hFF;
    localparam logic [7:0] SUB_EXP = 8'h00;
    localparam logic [7:0] MUL_EXP = 8'hFF;
`else
    localparam logic [7:0] ADD_EXP = 8'h00;
    localparam logic [7:0] SUB_EXP = 8'h01;
    localparam logic [7:0] MUL_EXP = 8'h54;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives a full op from a negedge; returns in DONE with valid held.
    task automatic start_op(
        input  logic [2:0] op,
        input  logic [7:0] a,
        input  logic [7:0] b,
        output logic       by,
        output logic       d3,
        output logic       d4
    );
        bus.opcode_valid = 1'b1;
        bus.opcode = op[0];
        bus.data = a;
        @(negedge clk);
        by = bus.busy;
        bus.opcode = op[1];
        bus.data = b;
        @(negedge clk);
        bus.opcode = op[2];
        bus.data = 'x;
        @(negedge clk);
        d3 = bus.done;
        bus.opcode = 1'bx;
        @(negedge clk);
        d4 = bus.done;
    endtask

    task automatic finish_op();
        bus.opcode_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.opcode_valid = 1'b0;
        bus.opcode = 1'b0;
        bus.data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.overflow, bus.result} !== 11'd0) begin
            errors++;
            $display("FAIL reset_out got %b/%b/%b/%h want 0/0/0/00",
                     bus.busy, bus.done, bus.overflow, bus.result);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        logic by, d3, d4;
        start_op(3'b000, 8'hFF, 8'h01, by, d3, d4);
        checks++;
        if ({by, d3, d4} !== 3'b101) begin
            errors++;
            $display("FAIL add_latency busy/d3/d4 got %b%b%b want 101",
                     by, d3, d4);
        end
        checks++;
        if ({bus.overflow, bus.result} !== {1'b1, ADD_EXP}) begin
            errors++;
            $display("FAIL add_res got %b/%h want 1/%h",
                     bus.overflow, bus.result, ADD_EXP);
        end
        bus.data = 8'h77;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.done, bus.busy, bus.result} !== {2'b11, ADD_EXP}) begin
            errors++;
            $display("FAIL add_hold got %b%b/%h want 11/%h",
                     bus.done, bus.busy, bus.result, ADD_EXP);
        end
        finish_op();
        checks++;
        if ({bus.done, bus.busy, bus.result} !== {2'b00, ADD_EXP}) begin
            errors++;
            $display("FAIL add_release got %b%b/%h want 00/%h",
                     bus.done, bus.busy, bus.result, ADD_EXP);
        end
    endtask

    task automatic test_sub();
        logic by, d3, d4;
        start_op(3'b001, 8'h00, 8'hFF, by, d3, d4);
        checks++;
        if ({d4, bus.overflow, bus.result} !== {2'b11, SUB_EXP}) begin
            errors++;
            $display("FAIL sub got %b%b/%h want 11/%h",
                     d4, bus.overflow, bus.result, SUB_EXP);
        end
        finish_op();
    endtask

    task automatic test_par();
        logic by, d3, d4;
        start_op(3'b010, 8'hAA, 8'h55, by, d3, d4);
        checks++;
        if ({d4, bus.overflow, bus.result} !== {2'b10, 8'h00}) begin
            errors++;
            $display("FAIL par got %b%b/%h want 10/00",
                     d4, bus.overflow, bus.result);
        end
        finish_op();
        start_op(3'b010, 8'hA8, 8'h55, by, d3, d4);
        checks++;
        if (bus.result !== 8'h01) begin
            errors++;
            $display("FAIL par_odd got %h want 01", bus.result);
        end
        finish_op();
    endtask

    task automatic test_comp();
        logic by, d3, d4;
        start_op(3'b011, 8'h20, 8'hDF, by, d3, d4);
        checks++;
        if ({bus.overflow, bus.result} !== {1'b0, 8'h04}) begin
            errors++;
            $display("FAIL comp_lt got %b/%h want 0/04",
                     bus.overflow, bus.result);
        end
        finish_op();
        start_op(3'b011, 8'hC2, 8'hC2, by, d3, d4);
        checks++;
        if (bus.result !== 8'h01) begin
            errors++;
            $display("FAIL comp_eq got %h want 01", bus.result);
        end
        finish_op();
        start_op(3'b011, 8'hC3, 8'hC2, by, d3, d4);
        checks++;
        if (bus.result !== 8'h02) begin
            errors++;
            $display("FAIL comp_gt got %h want 02", bus.result);
        end
        finish_op();
    endtask

    task automatic test_logic();
        logic by, d3, d4;
        start_op(3'b100, 8'h98, 8'h6B, by, d3, d4);
        checks++;
        if ({bus.overflow, bus.result} !== {1'b0, 8'h08}) begin
            errors++;
            $display("FAIL and got %b/%h want 0/08",
                     bus.overflow, bus.result);
        end
        finish_op();
        start_op(3'b101, 8'h98, 8'h6B, by, d3, d4);
        checks++;
        if (bus.result !== 8'hFB) begin
            errors++;
            $display("FAIL or got %h want FB", bus.result);
        end
        finish_op();
        start_op(3'b110, 8'h98, 8'h6B, by, d3, d4);
        checks++;
        if (bus.result !== 8'hF3) begin
            errors++;
            $display("FAIL xor got %h want F3", bus.result);
        end
        finish_op();
    endtask

    task automatic test_mul();
        logic by, d3, d4;
        start_op(3'b111, 8'h33, 8'h5C, by, d3, d4);
        checks++;
        if ({bus.overflow, bus.result} !== {1'b1, MUL_EXP}) begin
            errors++;
            $display("FAIL mul_ovf got %b/%h want 1/%h",
                     bus.overflow, bus.result, MUL_EXP);
        end
        finish_op();
        start_op(3'b111, 8'h0F, 8'h0F, by, d3, d4);
        checks++;
        if ({bus.overflow, bus.result} !== {1'b0, 8'hE1}) begin
            errors++;
            $display("FAIL mul got %b/%h want 0/E1",
                     bus.overflow, bus.result);
        end
        finish_op();
    endtask

    task automatic test_abort();
        logic by, d3, d4;
        start_op(3'b100, 8'h98, 8'h6B, by, d3, d4);
        finish_op();
        bus.opcode_valid = 1'b1;
        bus.opcode = 1'b1;
        bus.data = 8'h11;
        @(negedge clk);
        bus.opcode = 1'b0;
        bus.data = 8'h22;
        @(negedge clk);
        bus.opcode_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.result} !== {2'b00, 8'h08}) begin
            errors++;
            $display("FAIL abort got %b%b/%h want 00/08",
                     bus.busy, bus.done, bus.result);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL abort_done got %b want 0", bus.done);
        end
        start_op(3'b110, 8'h98, 8'h6B, by, d3, d4);
        checks++;
        if ({d3, d4, bus.result} !== {2'b01, 8'hF3}) begin
            errors++;
            $display("FAIL abort_next got %b%b/%h want 01/F3",
                     d3, d4, bus.result);
        end
        finish_op();
    endtask

    task automatic test_back_to_back();
        logic by, d3, d4;
        start_op(3'b000, 8'h12, 8'h34, by, d3, d4);
        checks++;
        if ({bus.overflow, bus.result} !== {1'b0, 8'h46}) begin
            errors++;
            $display("FAIL b2b_add got %b/%h want 0/46",
                     bus.overflow, bus.result);
        end
        finish_op();
        start_op(3'b001, 8'h05, 8'h03, by, d3, d4);
        checks++;
        if ({d4, bus.overflow, bus.result} !== {2'b10, 8'h02}) begin
            errors++;
            $display("FAIL b2b_sub got %b%b/%h want 10/02",
                     d4, bus.overflow, bus.result);
        end
        finish_op();
    endtask

    task automatic test_reset_mid();
        logic by, d3, d4;
        bus.opcode_valid = 1'b1;
        bus.opcode = 1'b1;
        bus.data = 8'h0F;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.overflow, bus.result} !== 11'd0) begin
            errors++;
            $display("FAIL rst_collect got %b%b%b/%h want 000/00",
                     bus.busy, bus.done, bus.overflow, bus.result);
        end
        bus.opcode_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        start_op(3'b111, 8'h0F, 8'h0F, by, d3, d4);
        checks++;
        if ({d4, bus.overflow, bus.result} !== {2'b10, 8'hE1}) begin
            errors++;
            $display("FAIL rst_collect_next got %b%b/%h want 10/E1",
                     d4, bus.overflow, bus.result);
        end
        finish_op();
        start_op(3'b111, 8'h33, 8'h5C, by, d3, d4);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.overflow, bus.result} !== 11'd0) begin
            errors++;
            $display("FAIL rst_done got %b%b%b/%h want 000/00",
                     bus.busy, bus.done, bus.overflow, bus.result);
        end
        bus.opcode_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        start_op(3'b101, 8'h98, 8'h6B, by, d3, d4);
        checks++;
        if ({d4, bus.result} !== {1'b1, 8'hFB}) begin
            errors++;
            $display("FAIL rst_done_next got %b/%h want 1/FB",
                     d4, bus.result);
        end
        finish_op();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add();
        test_sub();
        test_par();
        test_comp();
        test_logic();
        test_mul();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
